// File: rtl/pipe_stage_reg.sv
// Pipeline stage register between two stages: valid/ready handshake with optional skid entry,
// ordinary and exception flush, and a saturating stall-cycle counter.
module pipe_stage_reg #(
    parameter int              DATA_W     = 64,
    parameter int              PC_W       = 32,
    parameter logic [PC_W-1:0] RESET_PC   = 'h0000_3000,
    parameter logic [PC_W-1:0] HANDLER_PC = 'h0000_4180,
    parameter bit              SKID       = 1'b1,
    parameter int              CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              main_valid;
    logic [PC_W-1:0]   main_pc;
    logic [DATA_W-1:0] main_data;
    logic              skid_valid;
    logic [PC_W-1:0]   skid_pc;
    logic [DATA_W-1:0] skid_data;
    logic              accept;
    logic              main_free;
    logic              stalled;

    // With a skid entry, in_ready comes straight from a flop; without it, it looks through to out_ready.
    assign in_ready  = SKID ? !skid_valid : (!main_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign main_free = !main_valid || out_ready;
    assign stalled   = main_valid && !out_ready;

    assign out_valid = main_valid;
    assign out_pc    = main_pc;
    assign out_data  = main_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid <= 1'b0;
            main_pc    <= RESET_PC;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_pc    <= '0;
            skid_data  <= '0;
            stall_cnt  <= '0;
        end else begin
            if (stalled && !req && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);

            if (req) begin
                main_valid <= 1'b0;
                main_pc    <= HANDLER_PC;
                main_data  <= '0;
                skid_valid <= 1'b0;
            end else if (flush) begin
                main_valid <= 1'b0;
                main_data  <= '0;
                skid_valid <= 1'b0;
            end else if (main_free) begin
                // A parked skid entry always goes first to keep FIFO order.
                if (skid_valid) begin
                    main_valid <= 1'b1;
                    main_pc    <= skid_pc;
                    main_data  <= skid_data;
                    skid_valid <= 1'b0;
                end else if (accept) begin
                    main_valid <= 1'b1;
                    main_pc    <= in_pc;
                    main_data  <= in_data;
                end else begin
                    main_valid <= 1'b0;
                end
            end else if (accept) begin
                skid_valid <= 1'b1;
                skid_pc    <= in_pc;
                skid_data  <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid instance and a no-skid/4-bit-counter instance share stimulus
// and are each compared every cycle against a small FIFO model.
module tb_pipe_stage_reg;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] HND_PC = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        reset, req, flush, in_valid, out_ready;
    logic [31:0] in_pc;
    logic [63:0] in_data;

    logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
    logic [31:0] out_pc_a, out_pc_b;
    logic [63:0] out_data_a, out_data_b;
    logic [15:0] stall_cnt_a;
    logic [3:0]  stall_cnt_b;

    int checks = 0;
    int errors = 0;

    // Model: per instance, FIFO of {pc,data} entries, last shown head, stall count.
    logic [95:0] ment   [2][2];
    int          mcnt   [2];
    logic [95:0] mlast  [2];
    int          msc    [2];
    int          mscmax [2] = '{65535, 15};
    bit          mskid  [2] = '{1'b1, 1'b0};

    pipe_stage_reg dut_a (
        .clk(clk), .reset(reset), .req(req), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_pc(in_pc), .in_data(in_data),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_pc(out_pc_a),
        .out_data(out_data_a), .stall_cnt(stall_cnt_a)
    );

    pipe_stage_reg #(.SKID(1'b0), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .req(req), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_pc(in_pc), .in_data(in_data),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_pc(out_pc_b),
        .out_data(out_data_b), .stall_cnt(stall_cnt_b)
    );

    always #5 clk = ~clk;

    function automatic bit expReady(int k);
        return mskid[k] ? (mcnt[k] < 2) : (mcnt[k] == 0 || out_ready);
    endfunction

    function automatic logic [95:0] expHead(int k);
        return (mcnt[k] > 0) ? ment[k][0] : mlast[k];
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkAll();
        logic [95:0] ha, hb;
        ha = expHead(0);
        hb = expHead(1);
        checkOutput("a.in_ready",  64'(in_ready_a),  64'(expReady(0)));
        checkOutput("a.out_valid", 64'(out_valid_a), 64'(mcnt[0] > 0));
        checkOutput("a.out_pc",    64'(out_pc_a),    64'(ha[95:64]));
        checkOutput("a.out_data",  out_data_a,       ha[63:0]);
        checkOutput("a.stall_cnt", 64'(stall_cnt_a), 64'(msc[0]));
        checkOutput("b.in_ready",  64'(in_ready_b),  64'(expReady(1)));
        checkOutput("b.out_valid", 64'(out_valid_b), 64'(mcnt[1] > 0));
        checkOutput("b.out_pc",    64'(out_pc_b),    64'(hb[95:64]));
        checkOutput("b.out_data",  out_data_b,       hb[63:0]);
        checkOutput("b.stall_cnt", 64'(stall_cnt_b), 64'(msc[1]));
    endtask

    // Clock-edge update of one model from the inputs that were present at the edge.
    task automatic modelStep(int k);
        bit          acc, rel;
        logic [95:0] head;
        acc  = in_valid && expReady(k);
        rel  = (mcnt[k] > 0) && out_ready;
        head = expHead(k);
        if (reset) begin
            mcnt[k] = 0; mlast[k] = {RST_PC, 64'd0}; msc[k] = 0;
        end else begin
            if (!req && mcnt[k] > 0 && !out_ready && msc[k] < mscmax[k]) msc[k]++;
            if (req) begin
                mcnt[k] = 0; mlast[k] = {HND_PC, 64'd0};
            end else if (flush) begin
                mcnt[k] = 0; mlast[k] = {head[95:64], 64'd0};
            end else begin
                if (rel) begin
                    mlast[k] = ment[k][0];
                    ment[k][0] = ment[k][1];
                    mcnt[k]--;
                end
                if (acc) begin
                    ment[k][mcnt[k]] = {in_pc, in_data};
                    mcnt[k]++;
                end
            end
        end
    endtask

    task automatic applyStimulus(input bit r, input bit rq, input bit fl, input bit iv,
                                 input logic [31:0] pc, input logic [63:0] d, input bit ordy);
        reset = r; req = rq; flush = fl; in_valid = iv; in_pc = pc; in_data = d; out_ready = ordy;
        #1;
        checkAll();
        @(posedge clk);
        modelStep(0);
        modelStep(1);
        #1;
    endtask

    logic [31:0] nextPc;
    bit          rdy;

    initial begin
        reset = 1'b1; req = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_data = '0;
        @(posedge clk);
        modelStep(0);
        modelStep(1);
        #1;
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // Streaming with downstream always ready.
        for (int i = 0; i < 4; i++)
            applyStimulus(0, 0, 0, 1, RST_PC + 32'(4 * i), 64'(100 + i), 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);

        // Backpressure: upstream advances only when the skid instance accepts.
        nextPc = 32'h0000_3010;
        for (int n = 0; n < 12; n++) begin
            rdy = expReady(0);
            applyStimulus(0, 0, 0, nextPc < 32'h0000_301C, nextPc, {32'hA, nextPc}, n >= 6);
            if (rdy && nextPc < 32'h0000_301C) nextPc += 4;
        end

        // Exception request with both entries full and an entry on offer.
        applyStimulus(0, 0, 0, 1, 32'h0000_5000, 64'h55, 0);
        applyStimulus(0, 0, 0, 1, 32'h0000_5004, 64'h56, 0);
        applyStimulus(0, 1, 0, 1, 32'h0000_5008, 64'h57, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // Ordinary flush keeps out_pc; req wins over flush.
        applyStimulus(0, 0, 0, 1, 32'h0000_3010, 64'h77, 0);
        applyStimulus(0, 0, 1, 1, 32'h0000_3014, 64'h78, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // Long stall saturates the narrow counter.
        applyStimulus(0, 0, 0, 1, 32'h0000_6000, 64'h99, 0);
        for (int n = 0; n < 20; n++)
            applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 32'h0000_6004, 64'h9A, 0);

        // Randomized traffic with occasional flush, req and reset.
        for (int n = 0; n < 3000; n++)
            applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
                          $urandom_range(0, 29) == 0, $urandom_range(0, 2) != 0,
                          $urandom, {$urandom, $urandom}, $urandom_range(0, 2) != 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
